jvm_bytecode_fetch: RTL and testbench

//   Bytecode prefetch unit, directly upstream of the byte-wide JVM memory (start/ready, rwn=1 reads).

---
 rtl/jvm_bytecode_fetch.sv | 127 ++++++++++++
 tb/tb_jvm_bytecode_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_bytecode_fetch.sv
// Bytecode prefetch unit: issues one byte read at a time to the JVM memory and
// buffers returned bytes (with their PC) in a small FIFO for the decoder.
module jvm_bytecode_fetch #(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       FIFO_DEPTH    = 4,
    parameter int                       FIFO_PTR_W    = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_rwn,
    output logic [7:0]               mem_wdata,
    output logic                     mem_start,
    input  logic                     mem_ready,
    input  logic [7:0]               mem_rdata,
    output logic                     op_valid,
    output logic [7:0]               op_byte,
    output logic [ADDRESS_WIDTH-1:0] op_pc,
    input  logic                     op_accept,
    output logic [FIFO_PTR_W:0]      fifo_count,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, REQ, BUSY, PEND} state_t;

    localparam logic [FIFO_PTR_W:0] DEPTH_C = (FIFO_PTR_W+1)'(FIFO_DEPTH);

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic                       discard_q, discard_d;
    logic [FIFO_PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [FIFO_PTR_W:0]        count_q;
    logic [7:0]                 byte_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0]   bpc_q  [FIFO_DEPTH];
    logic                       push, pop, full;

    assign full = (count_q == DEPTH_C);
    assign pop  = op_valid && op_accept && !redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        push      = 1'b0;
        case (state_q)
            IDLE: if (run && mem_ready && !full && !redirect) begin
                state_d = REQ;
                addr_d  = pc_q;
            end
            REQ: begin
                pc_d    = pc_q + ADDRESS_WIDTH'(1);
                state_d = BUSY;
            end
            BUSY: if (!mem_ready) state_d = PEND;
            PEND: if (mem_ready) begin
                push      = !discard_q && !redirect;
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The memory transaction always runs to completion; a redirect only marks its byte stale.
        if (redirect) begin
            pc_d = redirect_pc;
            if (state_q != IDLE && !(state_q == PEND && mem_ready)) discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                byte_q[i] <= '0;
                bpc_q[i]  <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                byte_q[wr_ptr_q] <= mem_rdata;
                bpc_q[wr_ptr_q]  <= addr_q;
                wr_ptr_q         <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign mem_start   = (state_q == REQ);
    assign mem_address = addr_q;
    assign mem_rwn     = 1'b1;
    assign mem_wdata   = 8'h00;
    assign busy        = (state_q != IDLE);
    assign op_valid    = (count_q != '0);
    assign op_byte     = byte_q[rd_ptr_q];
    assign op_pc       = bpc_q[rd_ptr_q];
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_jvm_bytecode_fetch.sv
// Directed bench for jvm_bytecode_fetch: two instances (RESET_PC 0 and FE) behind
// a simple start/ready memory model where mem[a] = a + 10.
module tb_jvm_bytecode_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run [2], redirect [2], acc [2];
    logic [7:0] rpc [2];
    logic [7:0] maddr [2], mwdata [2], mrdata [2], opb [2], oppc [2];
    logic       mrwn [2], mstart [2], mready [2], opv [2], bsy [2];
    logic [2:0] fcnt [2];

    int         lat;
    int         wcnt [2];
    logic [7:0] raddr [2];
    logic [15:0] sbA [$];
    logic [15:0] sbB [$];
    int         n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    jvm_bytecode_fetch u_a (
        .clk(clk), .reset(rst_n), .run(run[0]), .redirect(redirect[0]), .redirect_pc(rpc[0]),
        .mem_address(maddr[0]), .mem_rwn(mrwn[0]), .mem_wdata(mwdata[0]), .mem_start(mstart[0]),
        .mem_ready(mready[0]), .mem_rdata(mrdata[0]), .op_valid(opv[0]), .op_byte(opb[0]),
        .op_pc(oppc[0]), .op_accept(acc[0]), .fifo_count(fcnt[0]), .busy(bsy[0]));

    jvm_bytecode_fetch #(.RESET_PC(8'hFE)) u_b (
        .clk(clk), .reset(rst_n), .run(run[1]), .redirect(redirect[1]), .redirect_pc(rpc[1]),
        .mem_address(maddr[1]), .mem_rwn(mrwn[1]), .mem_wdata(mwdata[1]), .mem_start(mstart[1]),
        .mem_ready(mready[1]), .mem_rdata(mrdata[1]), .op_valid(opv[1]), .op_byte(opb[1]),
        .op_pc(oppc[1]), .op_accept(acc[1]), .fifo_count(fcnt[1]), .busy(bsy[1]));

    // Memory model: ready drops the edge after start, returns after lat extra cycles.
    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                mready[g] <= 1'b1;
                mrdata[g] <= 8'h00;
                wcnt[g]   <= 0;
            end else if (mready[g] && mstart[g]) begin
                mready[g] <= 1'b0;
                wcnt[g]   <= lat;
                raddr[g]  <= maddr[g];
            end else if (!mready[g]) begin
                if (wcnt[g] == 0) begin
                    mready[g] <= 1'b1;
                    mrdata[g] <= raddr[g] + 8'd10;
                end else wcnt[g] <= wcnt[g] - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] pc);
        logic [7:0] b;
        b = pc + 8'd10;
        if (d == 0) sbA.push_back({b, pc});
        else        sbB.push_back({b, pc});
    endtask

    task automatic mon_port(input int d);
        logic [15:0] e;
        int          n;
        n = (d == 0) ? sbA.size() : sbB.size();
        chk(d == 0 ? "A_pop_expected" : "B_pop_expected", 32'(n > 0), 1);
        if (n > 0) begin
            e = (d == 0) ? sbA.pop_front() : sbB.pop_front();
            chk(d == 0 ? "A_byte_pc" : "B_byte_pc", {16'h0, opb[d], oppc[d]}, {16'h0, e});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (opv[0] && acc[0] && !redirect[0]) mon_port(0);
            if (opv[1] && acc[1] && !redirect[1]) mon_port(1);
        end
    end

    task automatic wait_start(input int d, input logic [7:0] ea, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (mstart[d]) seen = 1'b1;
            else cyc(1);
        end
        chk({tag, "_seen"}, 32'(seen), 1);
        if (seen) chk(tag, 32'(maddr[d]), 32'(ea));
    endtask

    task automatic drain(input int d, input string tag);
        int n;
        for (int i = 0; i < 400; i++) begin
            n = (d == 0) ? sbA.size() : sbB.size();
            if (n == 0) break;
            cyc(1);
        end
        n = (d == 0) ? sbA.size() : sbB.size();
        chk(tag, 32'(n), 0);
    endtask

    task automatic count_starts(input int d, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc(1);
            if (mstart[d]) n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(mstart[0]), 0);
        chk({tag, "_addr"},  32'(maddr[0]), 0);
        chk({tag, "_rwn"},   32'(mrwn[0]), 1);
        chk({tag, "_wdata"}, 32'(mwdata[0]), 0);
        chk({tag, "_valid"}, 32'(opv[0]), 0);
        chk({tag, "_byte"},  32'(opb[0]), 0);
        chk({tag, "_pc"},    32'(oppc[0]), 0);
        chk({tag, "_count"}, 32'(fcnt[0]), 0);
        chk({tag, "_busy"},  32'(bsy[0]), 0);
        chk({tag, "_b_addr"}, 32'(maddr[1]), 0);
    endtask

    initial begin
        int n;
        int w;
        rst_n = 1'b0;
        lat   = 0;
        for (int g = 0; g < 2; g++) begin
            run[g] = 1'b0; redirect[g] = 1'b0; acc[g] = 1'b0; rpc[g] = 8'h00;
        end
        cyc(3);
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc(1);

        // Streaming with the decoder always accepting
        for (int p = 0; p < 6; p++) push_exp(0, 8'(p));
        run[0] = 1'b1;
        acc[0] = 1'b1;
        wait_start(0, 8'h00, "t1_first_addr");
        drain(0, "t1_drain");
        acc[0] = 1'b0;

        // Decoder stalls: FIFO fills to depth and issue stops
        w = 0;
        while (fcnt[0] != 3'd4 && w < 100) begin cyc(1); w++; end
        chk("t2_full_count", 32'(fcnt[0]), 4);
        count_starts(0, 20, n);
        chk("t2_no_start_when_full", 32'(n), 0);
        chk("t2_idle_when_full", 32'(bsy[0]), 0);
        push_exp(0, 8'd6);
        acc[0] = 1'b1; cyc(1); acc[0] = 1'b0;
        wait_start(0, 8'd10, "t2_refill_addr");
        count_starts(0, 20, n);
        chk("t2_single_refill", 32'(n), 0);
        chk("t2_full_again", 32'(fcnt[0]), 4);

        // Redirect while the read is in BUSY: in-flight byte dropped
        push_exp(0, 8'd7);
        acc[0] = 1'b1; cyc(1); acc[0] = 1'b0;
        wait_start(0, 8'd11, "t3_inflight_addr");
        cyc(1);
        chk("t3_in_busy", 32'(bsy[0]), 1);
        redirect[0] = 1'b1; rpc[0] = 8'h40;
        cyc(1);
        redirect[0] = 1'b0;
        chk("t3_flush_valid", 32'(opv[0]), 0);
        chk("t3_flush_count", 32'(fcnt[0]), 0);
        wait_start(0, 8'h40, "t3_redirect_addr");
        for (int p = 0; p < 3; p++) push_exp(0, 8'(8'h40 + p));
        acc[0] = 1'b1;
        drain(0, "t3_drain");

        // Quiesce at a known PC, then drop run during REQ
        acc[0] = 1'b0;
        run[0] = 1'b0;
        redirect[0] = 1'b1; rpc[0] = 8'h80;
        cyc(1);
        redirect[0] = 1'b0;
        cyc(20);
        chk("t5_quiet_busy", 32'(bsy[0]), 0);
        chk("t5_quiet_count", 32'(fcnt[0]), 0);
        run[0] = 1'b1;
        wait_start(0, 8'h80, "t5_addr");
        run[0] = 1'b0;
        count_starts(0, 30, n);
        chk("t5_no_start_run0", 32'(n), 0);
        chk("t5_pushed", 32'(fcnt[0]), 1);
        push_exp(0, 8'h80);
        acc[0] = 1'b1;
        drain(0, "t5_drain");
        acc[0] = 1'b0;
        lat = 3;
        run[0] = 1'b1;
        wait_start(0, 8'h81, "t5_resume_addr");

        // Reset asserted while waiting in PEND
        cyc(2);
        chk("t6_in_pend", 32'(bsy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        sbA.delete();
        lat = 0;
        cyc(2);
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) push_exp(0, 8'(p));
        acc[0] = 1'b1;
        wait_start(0, 8'h00, "t6_restart_addr");
        drain(0, "t6_drain");
        run[0] = 1'b0;
        acc[0] = 1'b0;

        // RESET_PC = FE instance: PC wraps FE, FF, 00, 01
        push_exp(1, 8'hFE); push_exp(1, 8'hFF); push_exp(1, 8'h00); push_exp(1, 8'h01);
        run[1] = 1'b1;
        acc[1] = 1'b1;
        wait_start(1, 8'hFE, "t4_first_addr");
        drain(1, "t4_drain");
        run[1] = 1'b0;
        acc[1] = 1'b0;
        cyc(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
